execution_branch_resolve: RTL and testbench
===========================================

EXECUTION_BRANCH_RESOLVE -- requirements
Module: execution_branch_resolve

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: stall  in  1  hold all EX/MEM state.
REQ-004 SHALL have ports: flush  in  1  external synchronous kill of the instruction being captured.
REQ-005 SHALL have ports: ex_valid  in  1  EX-stage instruction valid.
REQ-006 SHALL have ports: ex_pc_plus4  in  32  PC+4 of the EX-stage instruction.
REQ-007 SHALL have ports: ex_offset_shifted  in  32  sign-extended branch offset already shifted left by 2.
REQ-008 SHALL have ports: ex_branch, ex_branch_ne  in  1 each  branch instruction; 1 = bne, 0 = beq.
REQ-009 SHALL have ports: ex_zero  in  1  ALU zero flag.
REQ-010 SHALL have ports: ex_alu_result, ex_write_data  in  32 each; ex_write_reg  in  5.
REQ-011 SHALL have ports: ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  in  1 each  control bits.
REQ-012 SHALL have ports: mem_valid  out  1; mem_pc_src  out  1  branch taken, selects mem_branch_target for PC.
REQ-013 SHALL have ports: mem_branch_target, mem_alu_result, mem_write_data  out  32 each; mem_write_reg  out  5.
REQ-014 SHALL have ports: mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  out  1 each.
REQ-015 SHALL have ports: flush_out  out  1  kill IF/ID and ID/EX; equals mem_pc_src.
REQ-016 SHALL have ports: taken_count  out  16  saturating count of taken branches.

Function
REQ-017 SHALL compute target = ex_pc_plus4 + ex_offset_shifted, modulo 2^32, with carry discarded.
REQ-018 SHALL compute taken = ex_valid & ex_branch & (ex_zero XOR ex_branch_ne).
REQ-019 SHALL register all mem_* outputs with one-cycle latency and drive them purely from flops, with no combinational input-to-output path.
REQ-020 SHALL use an internal squash flag, squash_q, set on each edge at which a taken branch is captured and cleared on every other non-stalled edge.
REQ-021 SHALL apply per-edge priority: flush, then stall, then squash_q, then normal load.
REQ-022 SHALL on flush set mem_valid, mem_pc_src, the four control outputs and squash_q to 0; data outputs are don't-care.
REQ-023 SHALL on stall without flush hold every output, squash_q and taken_count unchanged; mem_pc_src stays asserted while stalled.
REQ-024 SHALL when squash_q=1 with no stall or flush capture a bubble: mem_valid, mem_pc_src and control outputs 0; this discards the wrong-path EX instruction.
REQ-025 SHALL on normal load capture all ex_* values, set mem_valid=ex_valid and mem_pc_src=taken, and force the control outputs to 0 when ex_valid=0.
REQ-026 SHALL increment taken_count by 1 only on a normal load with taken=1, saturating at 16'hFFFF and never wrapping.
REQ-027 SHALL treat a taken branch followed immediately by another branch as follows: the second branch is squashed by REQ-024 and is neither counted nor taken.
REQ-028 SHALL capture mem_branch_target on every normal load, taken or not, for debug visibility.

Reset
REQ-029 SHALL on rst_n=0, asynchronously and independent of clk, clear all outputs, squash_q and taken_count to 0.
REQ-030 SHALL resume capture at the first rising edge after rst_n deasserts; reset asserted mid-stall or mid-squash leaves no residual squash.

Verification
REQ-031 SHALL cover beq taken: pc_plus4=0x00400010, offset_shifted=0x00000020, zero=1, valid=1 -> next edge mem_pc_src=1, target=0x00400030, flush_out=1, taken_count=1.
REQ-032 SHALL cover negative offset and wrap: pc_plus4=0x00000004, offset_shifted=0xFFFFFFF8, bne with zero=0 -> target=0xFFFFFFFC, mem_pc_src=1.
REQ-033 SHALL cover squash: taken beq, then next cycle ex_valid=1 with reg_write=1 -> second edge mem_valid=0, reg_write=0, mem_pc_src=0, taken_count unchanged.
REQ-034 SHALL cover stall plus flush: stall=1 for 3 cycles after a taken branch -> outputs held, mem_pc_src=1 throughout; assert flush and stall together -> bubble captured.
REQ-035 SHALL cover saturation: preload 0xFFFE taken branches, then 3 more -> taken_count=0xFFFF and held.
REQ-036 SHALL cover async reset: drop rst_n between edges with squash_q=1 -> outputs 0 immediately; first post-reset instruction captured normally.

Source files
------------

// File: rtl/execution_branch_resolve.sv
// EX/MEM register with branch resolution: computes the target and the taken decision, and squashes the wrong-path slot.
// Latency 1 cycle, all outputs come from flops; stall holds every flop and flush kills the capture (flush wins).
module execution_branch_resolve #(
   // Lowering this only moves the saturation point of taken_count; keep the default for the full 16-bit range.
   parameter logic [15:0] CNT_SAT = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc_plus4,
   input  logic [31:0] ex_offset_shifted,
   input  logic        ex_branch,
   input  logic        ex_branch_ne,
   input  logic        ex_zero,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_write_data,
   input  logic [4:0]  ex_write_reg,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_mem_to_reg,
   output logic        mem_valid,
   output logic        mem_pc_src,
   output logic [31:0] mem_branch_target,
   output logic [31:0] mem_alu_result,
   output logic [31:0] mem_write_data,
   output logic [4:0]  mem_write_reg,
   output logic        mem_reg_write,
   output logic        mem_mem_read,
   output logic        mem_mem_write,
   output logic        mem_mem_to_reg,
   output logic        flush_out,
   output logic [15:0] taken_count
);

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
   } ctrl_t;

   logic [31:0] w_target;
   logic        w_taken;
   ctrl_t       w_ex_ctrl;

   logic        r_valid;
   logic        r_pc_src;
   logic        r_squash;
   logic [31:0] r_target;
   logic [31:0] r_alu_result;
   logic [31:0] r_write_data;
   logic [4:0]  r_write_reg;
   ctrl_t       r_ctrl;
   logic [15:0] r_taken_count;

   assign w_target  = ex_pc_plus4 + ex_offset_shifted;
   assign w_taken   = ex_valid & ex_branch & (ex_zero ^ ex_branch_ne);
   assign w_ex_ctrl = '{reg_write: ex_reg_write, mem_read: ex_mem_read,
                        mem_write: ex_mem_write, mem_to_reg: ex_mem_to_reg};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid       <= 1'b0;
         r_pc_src      <= 1'b0;
         r_squash      <= 1'b0;
         r_target      <= '0;
         r_alu_result  <= '0;
         r_write_data  <= '0;
         r_write_reg   <= '0;
         r_ctrl        <= '0;
         r_taken_count <= '0;
      end else if (flush) begin
         r_valid  <= 1'b0;
         r_pc_src <= 1'b0;
         r_ctrl   <= '0;
         r_squash <= 1'b0;
      end else if (!stall) begin
         if (r_squash) begin
            // Slot behind a taken branch is wrong-path: capture a bubble.
            r_valid  <= 1'b0;
            r_pc_src <= 1'b0;
            r_ctrl   <= '0;
            r_squash <= 1'b0;
         end else begin
            r_valid      <= ex_valid;
            r_pc_src     <= w_taken;
            r_squash     <= w_taken;
            r_target     <= w_target;
            r_alu_result <= ex_alu_result;
            r_write_data <= ex_write_data;
            r_write_reg  <= ex_write_reg;
            r_ctrl       <= ex_valid ? w_ex_ctrl : '0;
            if (w_taken && (r_taken_count != CNT_SAT)) begin
               r_taken_count <= r_taken_count + 16'd1;
            end
         end
      end
   end

   assign mem_valid         = r_valid;
   assign mem_pc_src        = r_pc_src;
   assign flush_out         = r_pc_src;
   assign mem_branch_target = r_target;
   assign mem_alu_result    = r_alu_result;
   assign mem_write_data    = r_write_data;
   assign mem_write_reg     = r_write_reg;
   assign mem_reg_write     = r_ctrl.reg_write;
   assign mem_mem_read      = r_ctrl.mem_read;
   assign mem_mem_write     = r_ctrl.mem_write;
   assign mem_mem_to_reg    = r_ctrl.mem_to_reg;
   assign taken_count       = r_taken_count;

endmodule

// File: tb/tb_execution_branch_resolve.sv
// Directed plus randomized checks of execution_branch_resolve against a rule-level reference model.
module tb_execution_branch_resolve;

   localparam logic [15:0] SAT = 16'h0030;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush;
   logic        ex_valid, ex_branch, ex_branch_ne, ex_zero;
   logic [31:0] ex_pc_plus4, ex_offset_shifted, ex_alu_result, ex_write_data;
   logic [4:0]  ex_write_reg;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic        mem_valid, mem_pc_src, flush_out;
   logic [31:0] mem_branch_target, mem_alu_result, mem_write_data;
   logic [4:0]  mem_write_reg;
   logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
   logic [15:0] taken_count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: what the MEM side should show, in plain terms.
   bit          m_valid, m_pc_src, m_wrong_path, m_data_known;
   bit [3:0]    m_ctrl;
   bit [31:0]   m_target, m_alu, m_wd;
   bit [4:0]    m_wr;
   int unsigned m_count;

   execution_branch_resolve #(.CNT_SAT(SAT)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_offset_shifted(ex_offset_shifted),
      .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_zero(ex_zero),
      .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data), .ex_write_reg(ex_write_reg),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg),
      .mem_valid(mem_valid), .mem_pc_src(mem_pc_src), .mem_branch_target(mem_branch_target),
      .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data), .mem_write_reg(mem_write_reg),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_mem_to_reg(mem_mem_to_reg), .flush_out(flush_out), .taken_count(taken_count)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_pc_src = 0; m_wrong_path = 0; m_ctrl = '0; m_count = 0;
      m_target = '0; m_alu = '0; m_wd = '0; m_wr = '0; m_data_known = 1;
   endtask

   task automatic model_edge();
      longint sum;
      bit     taken;
      if (flush) begin
         m_valid = 0; m_pc_src = 0; m_ctrl = '0; m_wrong_path = 0; m_data_known = 0;
      end else if (stall) begin
         // everything holds
      end else if (m_wrong_path) begin
         m_valid = 0; m_pc_src = 0; m_ctrl = '0; m_wrong_path = 0; m_data_known = 0;
      end else begin
         taken        = ex_valid && ex_branch && (ex_zero != ex_branch_ne);
         sum          = longint'(ex_pc_plus4) + longint'(ex_offset_shifted);
         m_target     = 32'(sum % 64'h1_0000_0000);
         m_alu        = ex_alu_result;
         m_wd         = ex_write_data;
         m_wr         = ex_write_reg;
         m_valid      = ex_valid;
         m_pc_src     = taken;
         m_ctrl       = ex_valid ? {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} : 4'b0;
         m_data_known = 1;
         if (taken && m_count < int'(SAT)) m_count++;
         m_wrong_path = taken;
      end
   endtask

   task automatic check_all();
      check("mem_valid", 32'(mem_valid), 32'(m_valid));
      check("mem_pc_src", 32'(mem_pc_src), 32'(m_pc_src));
      check("flush_out", 32'(flush_out), 32'(m_pc_src));
      check("ctrl", 32'({mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}), 32'(m_ctrl));
      check("taken_count", 32'(taken_count), m_count);
      if (m_data_known) begin
         check("target", mem_branch_target, m_target);
         check("alu_result", mem_alu_result, m_alu);
         check("write_data", mem_write_data, m_wd);
         check("write_reg", 32'(mem_write_reg), 32'(m_wr));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic rand_data();
      ex_alu_result = $urandom; ex_write_data = $urandom; ex_write_reg = 5'($urandom);
      {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} = 4'($urandom);
   endtask

   task automatic idle();
      stall = 0; flush = 0; ex_valid = 0; ex_branch = 0; ex_branch_ne = 0; ex_zero = 0;
      ex_pc_plus4 = '0; ex_offset_shifted = '0; rand_data();
   endtask

   task automatic br(input bit ne, input bit zero, input logic [31:0] pc4, input logic [31:0] off);
      ex_valid = 1; ex_branch = 1; ex_branch_ne = ne; ex_zero = zero;
      ex_pc_plus4 = pc4; ex_offset_shifted = off; rand_data();
   endtask

   task automatic alu_op();
      ex_valid = 1; ex_branch = 0; ex_branch_ne = 0; ex_zero = 0;
      ex_pc_plus4 = $urandom; ex_offset_shifted = $urandom; rand_data();
      ex_reg_write = 1;
   endtask

   initial begin
      rst_n = 0;
      idle();
      #1;
      model_reset();
      check_all();
      #11 rst_n = 1;

      // beq taken
      br(0, 1, 32'h0040_0010, 32'h0000_0020);
      step();
      check("beq_pc_src", 32'(mem_pc_src), 32'h1);
      check("beq_target", mem_branch_target, 32'h0040_0030);
      check("beq_flush_out", 32'(flush_out), 32'h1);
      check("beq_count", 32'(taken_count), 32'h1);

      // wrong-path instruction right behind it is squashed, even a branch
      br(0, 1, 32'h0000_1000, 32'h0000_0040);
      ex_reg_write = 1;
      step();
      check("sq_valid", 32'(mem_valid), 32'h0);
      check("sq_reg_write", 32'(mem_reg_write), 32'h0);
      check("sq_pc_src", 32'(mem_pc_src), 32'h0);
      check("sq_count", 32'(taken_count), 32'h1);

      // bne with negative offset wrapping below zero
      br(1, 0, 32'h0000_0004, 32'hFFFF_FFF8);
      step();
      check("neg_target", mem_branch_target, 32'hFFFF_FFFC);
      check("neg_pc_src", 32'(mem_pc_src), 32'h1);
      idle();
      step();

      // not-taken beq still records its target
      br(0, 0, 32'h0000_0100, 32'h0000_0010);
      step();
      check("nt_target", mem_branch_target, 32'h0000_0110);
      check("nt_pc_src", 32'(mem_pc_src), 32'h0);

      // stall holds a taken branch, then flush+stall captures a bubble
      br(0, 1, 32'h0000_2000, 32'h0000_0100);
      step();
      for (int i = 0; i < 3; i++) begin
         alu_op();
         stall = 1;
         step();
         check("stall_pc_src", 32'(mem_pc_src), 32'h1);
         check("stall_target", mem_branch_target, 32'h0000_2100);
      end
      br(0, 1, 32'h0000_3000, 32'h0000_0004);
      stall = 1; flush = 1;
      step();
      check("fl_valid", 32'(mem_valid), 32'h0);
      check("fl_pc_src", 32'(mem_pc_src), 32'h0);
      idle();
      alu_op();
      step();
      check("post_fl_valid", 32'(mem_valid), 32'h1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         ex_valid     = ($urandom % 4) != 0;
         ex_branch    = ($urandom % 3) == 0;
         ex_branch_ne = 1'($urandom);
         ex_zero      = 1'($urandom);
         ex_pc_plus4  = {$urandom, 2'b00} >> 2 << 2;
         ex_offset_shifted = {30'($urandom), 2'b00};
         rand_data();
         stall = ($urandom % 6) == 0;
         flush = ($urandom % 10) == 0;
         step();
      end

      // async reset while the squash flag is set
      idle();
      br(1, 0, 32'h0000_4000, 32'h0000_0008);
      step();
      alu_op();
      #2 rst_n = 0;
      #1;
      model_reset();
      check_all();
      check("arst_pc_src", 32'(mem_pc_src), 32'h0);
      #2 rst_n = 1;
      step();
      check("arst_resume_valid", 32'(mem_valid), 32'h1);
      check("arst_resume_rw", 32'(mem_reg_write), 32'h1);

      // async reset mid-stall behind a taken branch
      br(0, 1, 32'h0000_5000, 32'h0000_0010);
      step();
      stall = 1;
      step();
      #2 rst_n = 0;
      #1;
      model_reset();
      check_all();
      #2 rst_n = 1;
      idle();
      alu_op();
      step();
      check("arst_stall_valid", 32'(mem_valid), 32'h1);

      // saturation: preload SAT-1 taken branches, then three more
      while (m_count < int'(SAT) - 1) begin
         br(0, 1, $urandom, $urandom);
         step();
         idle();
         step();
      end
      check("pre_sat", 32'(taken_count), 32'(SAT) - 1);
      for (int i = 0; i < 3; i++) begin
         br(1, 0, $urandom, $urandom);
         step();
         check("sat_count", 32'(taken_count), 32'(SAT));
         idle();
         step();
      end
      check("sat_hold", 32'(taken_count), 32'(SAT));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
